ping_pong_ctrl_n: RTL and testbench
===================================

Name: ping_pong_ctrl_n

Overview:
- Sequences the two single-port banks of the north ping-pong buffer that bridges linear-projection output into the Qn x KnT matmul.
- Producer side: accepts a valid/ready write stream and fills one bank with a frame of DEPTH words while the consumer drains the other bank.
- Drives per-bank ena/wea/addra, the slicing_idx module selector and a bank-select for the dout mux.
- Exposes a valid/ready/last read stream to the consumer.

Parameters:
TOTAL_MODULES, 3, number of module slices; slicing_idx range 0..TOTAL_MODULES-1
COL_X, 16, column size of producer matrix X
TOTAL_INPUT_W, 2, input words per column
DEPTH (localparam), COL_X*TOTAL_INPUT_W, words per frame per bank
ADDR_WIDTH (localparam), $clog2(DEPTH), bank address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous soft reset, same effect as rst_n
in_valid  in  1  producer word available (data is routed straight to bankX_din)
in_ready  out  1  controller accepts a write this cycle
out_ready  in  1  consumer accepts out word
out_valid  out  1  bank dout (selected by out_bank_sel) holds a valid word
out_last  out  1  qualifies the final word (addr DEPTH-1) of a frame
out_bank_sel  out  1  0: consumer reads bank0_dout; 1: bank1_dout
slicing_idx  out  $clog2(TOTAL_MODULES)  module slice written into the current write bank
bank0_ena, bank0_wea  out  1 each  bank 0 enable / write enable
bank0_addra  out  ADDR_WIDTH  bank 0 address
bank1_ena, bank1_wea, bank1_addra  out  same as bank 0
bank_full  out  2  per-bank FULL or DRAINING status
frame_done  out  1  one-cycle pulse when a frame's last word is consumed

Behaviour:
- Reset (rst_n low, async; or clear high, sync):
  - Both banks EMPTY; wr_bank=0, rd_bank=0, wr_addr=0, rd_addr=0, slicing_idx=0.
  - All outputs 0.
- Bank states: EMPTY -> (first write) FILLING -> (DEPTH-th write) FULL -> (first read issue) DRAINING -> (last word consumed) EMPTY.
- Write path:
  - in_ready = state[wr_bank] is EMPTY or FILLING. Computed from registered state only, no combinational path from in_valid.
  - On in_valid & in_ready: bankN_ena=1, bankN_wea=1, bankN_addra=wr_addr (N=wr_bank), all combinational in the same cycle. wr_addr increments.
  - At wr_addr==DEPTH-1: bank goes FULL, wr_addr resets to 0, wr_bank toggles.
  - On that same transition, slicing_idx increments, wrapping TOTAL_MODULES-1 -> 0. slicing_idx is constant throughout a frame.
- Read path (RAM read latency 1):
  - Issue condition: state[rd_bank] is FULL or DRAINING, rd_addr not exhausted, and (!out_valid | out_ready).
  - On issue: bankN_ena=1, wea=0, addra=rd_addr. out_valid is set the next cycle. out_last is registered as (issued addr==DEPTH-1).
  - While out_valid & !out_ready: no issue and ena=0, so douta holds its value and stays stable.
  - Back-to-back issue on consume sustains 1 word/cycle.
  - out_bank_sel = bank of the word currently presented.
- Release:
  - A bank returns to EMPTY only on out_valid & out_ready & out_last, not at the last issue. This is required because WRITE_MODE write_first would overwrite douta.
  - On release: frame_done pulses, rd_bank toggles, rd_addr=0.
- Same-cycle events:
  - A write to wr_bank and a read of rd_bank in one cycle are legal only when the banks differ. By construction wr_bank != rd_bank whenever both are active.
  - A write to a bank released this cycle starts no earlier than the next cycle.
- Both banks FULL: in_ready=0 until a release.
- A frame completing its write while the other bank is EMPTY and idle is read starting the next cycle.
- Mid-operation reset/clear: partial frames are discarded. No stale out_valid after reset deasserts.
- Assertions:
  - Never both ena and wea on rd_bank while out_valid.
  - Never bank0 and bank1 written in the same cycle.

Test Plan:
1. DEPTH=32, in_valid held 1, out_ready held 1 -> bank0 addr 0..31 written over cycles 0..31. Bank1 then fills while bank0 drains 1 word/cycle, out_last on the 32nd word, frame_done pulses, slicing_idx 0->1->2->0 across frames 1..3.
2. out_ready=0 after first frame is full -> out_valid stays 1, bank0_ena=0, douta stable. Bank1 fills, then in_ready=0 (both full). Raising out_ready resumes at addr 1.
3. out_ready toggled 1010... -> each word presented exactly once, in order 0..31, no skip or duplicate. Bank0 stays non-writable until the last word is consumed.
4. in_valid sparse (1 every 3 cycles) -> wr_addr advances only on handshake. The frame completes after 32 accepts, and the read starts the cycle after FULL.
5. rst_n asserted at write addr 17 with reads in flight -> outputs 0 immediately. After release, the first write goes to bank0 addr 0 with slicing_idx=0.
6. clear pulsed for one cycle mid-drain -> same state as reset on the next cycle. No out_valid until a new full frame is written.

Source files
------------

// File: rtl/ping_pong_ctrl_n.sv
// North ping-pong buffer sequencer: fills one bank from the producer
// while the consumer drains the other, with a registered read stream.
module ping_pong_ctrl_n #(
  parameter int TOTAL_MODULES = 3,
  parameter int COL_X = 16,
  parameter int TOTAL_INPUT_W = 2,
  localparam int DEPTH = COL_X * TOTAL_INPUT_W,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int SLICE_W =
    (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  out_bank_sel,
  output logic [SLICE_W-1:0]    slicing_idx,
  output logic                  bank0_ena,
  output logic                  bank0_wea,
  output logic [ADDR_WIDTH-1:0] bank0_addra,
  output logic                  bank1_ena,
  output logic                  bank1_wea,
  output logic [ADDR_WIDTH-1:0] bank1_addra,
  output logic [1:0]            bank_full,
  output logic                  frame_done
);

  typedef enum logic [1:0] {
    EMPTY, FILLING, FULL, DRAINING
  } bank_e;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);
  localparam logic [SLICE_W-1:0] SLICE_LAST =
    SLICE_W'(TOTAL_MODULES - 1);

  bank_e st_q [2];
  bank_e st_d [2];

  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  rd_exh_q, rd_exh_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [SLICE_W-1:0]    slice_q, slice_d;
  logic                  ov_q, ov_d;
  logic                  ol_q, ol_d;
  logic                  sel_q, sel_d;

  logic wr_ok, rd_ok;
  logic wr_go, rd_go, rel;
  logic wr_last, rd_last;

  always_comb begin
    wr_ok = (st_q[wr_bank_q] == EMPTY) ||
            (st_q[wr_bank_q] == FILLING);
    rd_ok = (st_q[rd_bank_q] == FULL) ||
            (st_q[rd_bank_q] == DRAINING);
  end

  // in_ready depends on registered state only
  assign in_ready = rst_n & ~clear & wr_ok;
  assign wr_go    = in_valid & in_ready;
  assign rd_go    = rst_n & ~clear & rd_ok & ~rd_exh_q &
                    (~ov_q | out_ready);
  // release waits for consumption: a write_first
  // write would otherwise clobber the held douta
  assign rel      = ov_q & out_ready & ol_q;
  assign wr_last  = (wr_addr_q == LAST);
  assign rd_last  = (rd_addr_q == LAST);

  always_comb begin
    st_d[0]   = st_q[0];
    st_d[1]   = st_q[1];
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    rd_exh_d  = rd_exh_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    slice_d   = slice_q;
    ov_d      = ov_q;
    ol_d      = ol_q;
    sel_d     = sel_q;

    if (wr_go) begin
      st_d[wr_bank_q] = wr_last ? FULL : FILLING;
      wr_addr_d = wr_last ? '0 : wr_addr_q + 1'b1;
      if (wr_last) begin
        wr_bank_d = ~wr_bank_q;
        slice_d = (slice_q == SLICE_LAST) ?
                  '0 : slice_q + 1'b1;
      end
    end

    if (rd_go) begin
      st_d[rd_bank_q] = DRAINING;
      rd_addr_d = rd_last ? '0 : rd_addr_q + 1'b1;
      rd_exh_d  = rd_last;
      ov_d      = 1'b1;
      ol_d      = rd_last;
      sel_d     = rd_bank_q;
    end else if (out_ready) begin
      ov_d = 1'b0;
      ol_d = 1'b0;
    end

    if (rel) begin
      st_d[rd_bank_q] = EMPTY;
      rd_bank_d = ~rd_bank_q;
      rd_addr_d = '0;
      rd_exh_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]   <= EMPTY;
      st_q[1]   <= EMPTY;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_exh_q  <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      slice_q   <= '0;
      ov_q      <= 1'b0;
      ol_q      <= 1'b0;
      sel_q     <= 1'b0;
    end else if (clear) begin
      st_q[0]   <= EMPTY;
      st_q[1]   <= EMPTY;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_exh_q  <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      slice_q   <= '0;
      ov_q      <= 1'b0;
      ol_q      <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      st_q[0]   <= st_d[0];
      st_q[1]   <= st_d[1];
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_exh_q  <= rd_exh_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      slice_q   <= slice_d;
      ov_q      <= ov_d;
      ol_q      <= ol_d;
      sel_q     <= sel_d;
    end
  end

  always_comb begin
    bank0_ena   = 1'b0;
    bank0_wea   = 1'b0;
    bank0_addra = '0;
    bank1_ena   = 1'b0;
    bank1_wea   = 1'b0;
    bank1_addra = '0;
    unique case (1'b1)
      wr_go & ~wr_bank_q: begin
        bank0_ena   = 1'b1;
        bank0_wea   = 1'b1;
        bank0_addra = wr_addr_q;
      end
      wr_go & wr_bank_q: begin
        bank1_ena   = 1'b1;
        bank1_wea   = 1'b1;
        bank1_addra = wr_addr_q;
      end
      default: ;
    endcase
    // wr and rd never target the same bank
    unique case (1'b1)
      rd_go & ~rd_bank_q: begin
        bank0_ena   = 1'b1;
        bank0_addra = rd_addr_q;
      end
      rd_go & rd_bank_q: begin
        bank1_ena   = 1'b1;
        bank1_addra = rd_addr_q;
      end
      default: ;
    endcase
  end

  assign out_valid    = ov_q;
  assign out_last     = ol_q;
  assign out_bank_sel = sel_q;
  assign slicing_idx  = slice_q;
  assign frame_done   = rel;
  assign bank_full[0] = (st_q[0] == FULL) || (st_q[0] == DRAINING);
  assign bank_full[1] = (st_q[1] == FULL) || (st_q[1] == DRAINING);

  a_rd_bank_no_write: assert property (
    @(posedge clk) disable iff (!rst_n)
    ov_q |-> !(rd_bank_q ? (bank1_ena & bank1_wea)
                         : (bank0_ena & bank0_wea)));

  a_one_bank_written: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(bank0_wea & bank1_wea));

endmodule

// File: tb/tb_ping_pong_ctrl_n.sv
// Bench for ping_pong_ctrl_n: cycle table for streaming plus
// a write_first RAM model and scoreboard for multi-cycle cases.
module tb_ping_pong_ctrl_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_last, out_bank_sel;
  logic [1:0] slicing_idx;
  logic bank0_ena, bank0_wea, bank1_ena, bank1_wea;
  logic [4:0] bank0_addra, bank1_addra;
  logic [1:0] bank_full;
  logic frame_done;

  always #5 clk = ~clk;

  ping_pong_ctrl_n dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_last(out_last), .out_bank_sel(out_bank_sel),
    .slicing_idx(slicing_idx),
    .bank0_ena(bank0_ena), .bank0_wea(bank0_wea),
    .bank0_addra(bank0_addra),
    .bank1_ena(bank1_ena), .bank1_wea(bank1_wea),
    .bank1_addra(bank1_addra),
    .bank_full(bank_full), .frame_done(frame_done)
  );

  // write_first single-port RAMs, read latency 1
  logic [15:0] mem0 [32];
  logic [15:0] mem1 [32];
  logic [15:0] d0 = '0, d1 = '0, din = '0;
  always @(posedge clk) begin
    if (bank0_ena) begin
      if (bank0_wea) begin
        mem0[bank0_addra] <= din;
        d0 <= din;
      end else d0 <= mem0[bank0_addra];
    end
    if (bank1_ena) begin
      if (bank1_wea) begin
        mem1[bank1_addra] <= din;
        d1 <= din;
      end else d1 <= mem1[bank1_addra];
    end
  end

  typedef struct {
    logic ir, e0, w0, e1, w1, ov, ol, sel, fd;
    logic [1:0] sl;
    logic [4:0] a0, a1;
  } vec_t;

  vec_t tv [99];
  int tests = 0, fails = 0;
  logic [15:0] sb [$];
  int pushed = 0, cons = 0, popped = 0;
  logic [15:0] wval = 16'h100;
  logic rstv = 1'b0, clrv = 1'b0;

  task automatic chk(string nm, logic [63:0] got,
                     logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(vec_t v);
    return 64'({v.ir, v.e0, v.w0, v.e1, v.w1, v.ov, v.ol,
                v.sel, v.fd, v.sl,
                v.e0 ? v.a0 : 5'd0, v.e1 ? v.a1 : 5'd0});
  endfunction

  function automatic vec_t obs();
    vec_t v;
    v.ir = in_ready;  v.e0 = bank0_ena; v.w0 = bank0_wea;
    v.e1 = bank1_ena; v.w1 = bank1_wea; v.ov = out_valid;
    v.ol = out_last;  v.sel = out_bank_sel;
    v.fd = frame_done; v.sl = slicing_idx;
    v.a0 = bank0_addra; v.a1 = bank1_addra;
    return v;
  endfunction

  // producer push / consumer pop-and-compare
  task automatic mon();
    logic [15:0] e, g;
    logic el;
    if (in_valid && in_ready) begin
      din = wval;
      sb.push_back(wval);
      wval++;
      pushed++;
    end
    if (out_valid && out_ready) begin
      g = out_bank_sel ? d1 : d0;
      el = (cons == 31);
      chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rd_word", 64'({g, out_last, frame_done}),
            64'({e, el, el}));
      end
      cons = el ? 0 : cons + 1;
      popped++;
    end
  endtask

  task automatic step(logic iv, logic ordy);
    @(negedge clk);
    rst_n = rstv;
    clear = clrv;
    in_valid = iv;
    out_ready = ordy;
    #2;
    mon();
  endtask

  task automatic sb_reset();
    sb.delete();
    pushed = 0;
    cons = 0;
  endtask

  task automatic do_reset();
    rstv = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    sb_reset();
    rstv = 1'b1;
  endtask

  task automatic drain(int bound);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < bound) begin
      step(1'b0, 1'b1);
      n++;
    end
    chk("drain_done", 64'(sb.size() == 0 && !out_valid), 64'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: timeout expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0, ovc, pop0;
    logic prev_full;
    vec_t v;

    for (int c = 0; c < 99; c++) begin
      v = '{default: '0};
      if (c < 32) begin
        v.ir = 1; v.e0 = 1; v.w0 = 1; v.a0 = 5'(c);
      end else if (c < 64) begin
        v.ir = 1; v.e0 = 1; v.a0 = 5'(c - 32);
        v.e1 = 1; v.w1 = 1; v.a1 = 5'(c - 32);
        v.ov = (c >= 33); v.sl = 2'd1;
      end else if (c == 64) begin
        v.ov = 1; v.ol = 1; v.fd = 1; v.sl = 2'd2;
      end else if (c < 97) begin
        v.ir = 1; v.e0 = 1; v.w0 = 1; v.a0 = 5'(c - 65);
        v.e1 = 1; v.a1 = 5'(c - 65);
        v.ov = (c >= 66); v.sel = (c >= 66); v.sl = 2'd2;
      end else if (c == 97) begin
        v.ov = 1; v.ol = 1; v.sel = 1; v.fd = 1;
      end else begin
        v.ir = 1; v.e0 = 1; v.a0 = 5'd0;
        v.e1 = 1; v.w1 = 1; v.a1 = 5'd0; v.sel = 1;
      end
      tv[c] = v;
    end

    // reset state with inputs active
    rstv = 1'b0;
    step(1'b1, 1'b1);
    chk("reset_outs", 64'({in_ready, bank0_ena, bank0_wea,
        bank1_ena, bank1_wea, out_valid, out_last,
        out_bank_sel, frame_done, slicing_idx, bank_full,
        bank0_addra, bank1_addra}), 64'(0));

    // 1: continuous streaming across frames
    sb_reset();
    rstv = 1'b1;
    for (int c = 0; c < 99; c++) begin
      step(1'b1, 1'b1);
      chk($sformatf("t1_c%0d", c), pack(obs()), pack(tv[c]));
      if (c == 64)
        chk("t1_bank_full", 64'(bank_full), 64'(2'b11));
    end

    // 2: consumer stall with both banks full
    do_reset();
    for (int c = 0; c < 71; c++) step(1'b1, 1'b0);
    chk("t2_in_ready", 64'(in_ready), 64'(0));
    chk("t2_hold", 64'({out_valid, bank0_ena, bank1_ena,
        bank_full}), 64'({1'b1, 1'b0, 1'b0, 2'b11}));
    chk("t2_dout_stable", 64'(d0), 64'(sb[0]));
    step(1'b0, 1'b1);
    chk("t2_resume", 64'({bank0_ena, bank0_wea, bank0_addra}),
        64'({1'b1, 1'b0, 5'd1}));
    drain(200);

    // 3: consumer toggling 1010...
    do_reset();
    pop0 = popped;
    n = 0;
    while ((pushed < 96 || sb.size() != 0 || out_valid) &&
           n < 800) begin
      step(pushed < 96, (n % 2) == 0);
      n++;
    end
    chk("t3_done", 64'({pushed == 96, sb.size() == 0}),
        64'(2'b11));
    chk("t3_popped", 64'(popped - pop0), 64'(96));

    // 4: sparse producer, one word every 3 cycles
    do_reset();
    n = 0;
    prev_full = 1'b0;
    while (pushed < 32 && n < 200) begin
      p0 = pushed;
      step((n % 3) == 0, 1'b1);
      if (pushed != p0)
        chk("t4_waddr", 64'({bank0_wea, bank0_addra}),
            64'({1'b1, 5'(p0)}));
      n++;
    end
    chk("t4_cycles", 64'(n), 64'(94));
    step(1'b0, 1'b1);
    chk("t4_rd_start", 64'({bank0_ena, bank0_wea,
        bank0_addra, bank_full[0], prev_full}),
        64'({1'b1, 1'b0, 5'd0, 1'b1, 1'b0}));
    drain(100);

    // 5: async reset mid-frame with reads in flight
    do_reset();
    for (int c = 0; c < 50; c++) step(1'b1, 1'b1);
    chk("t5_pre", 64'({bank1_wea, bank1_addra, out_valid}),
        64'({1'b1, 5'd17, 1'b1}));
    rst_n = 1'b0;
    rstv = 1'b0;
    #1;
    chk("t5_async", 64'({in_ready, bank0_ena, bank1_ena,
        bank0_wea, bank1_wea, out_valid, out_last,
        frame_done, slicing_idx, bank_full}), 64'(0));
    step(1'b0, 1'b0);
    sb_reset();
    rstv = 1'b1;
    step(1'b1, 1'b1);
    chk("t5_first_wr", 64'({bank0_ena, bank0_wea,
        bank0_addra, bank1_ena, slicing_idx, out_valid}),
        64'({1'b1, 1'b1, 5'd0, 1'b0, 2'd0, 1'b0}));
    for (int c = 0; c < 31; c++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    drain(100);

    // 6: clear pulse mid-drain
    do_reset();
    for (int c = 0; c < 32; c++) step(1'b1, 1'b1);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b1);
    chk("t6_mid_drain", 64'({out_valid, slicing_idx}),
        64'({1'b1, 2'd1}));
    clrv = 1'b1;
    step(1'b0, 1'b0);
    clrv = 1'b0;
    sb_reset();
    step(1'b0, 1'b1);
    chk("t6_after", 64'({out_valid, out_last, in_ready,
        bank0_ena, bank1_ena, bank_full, slicing_idx,
        frame_done}), 64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
        2'b00, 2'd0, 1'b0}));
    ovc = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b1);
      if (out_valid) ovc++;
    end
    chk("t6_no_stale", 64'(ovc), 64'(0));
    step(1'b1, 1'b1);
    chk("t6_first_wr", 64'({bank0_wea, bank0_addra}),
        64'({1'b1, 5'd0}));
    for (int c = 0; c < 31; c++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    drain(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
